uart_frame_rx: RTL and testbench



---
 rtl/uart_frame_rx.sv | 226 ++++++++++++++++++++++
 tb/tb_uart_frame_rx.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_rx.sv
//------------------------------------------------------------------------------
// Module  : uart_frame_rx
// Brief   : 8N1 UART receiver with header hunt, NUM_BYTES payload, timeout and
//           error reporting. Macro UART_FRAME_CHECKSUM_EN adds a trailing
//           additive checksum byte and its comparison.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_frame_rx #(
    parameter int         CLK_FREQ     = 50_000_000,
    parameter int         UART_BPS     = 115200,
    parameter int         NUM_BYTES    = 5,
    parameter logic [7:0] HEADER       = 8'hA5,
    parameter int         TIMEOUT_BITS = 20
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst,
    input  logic                   uart_rxd,
    output logic [7:0]             byte_data,
    output logic                   byte_valid,
    output logic [8*NUM_BYTES-1:0] frame_data,
    output logic                   frame_valid,
    output logic                   frame_err,
    output logic [1:0]             err_code
);

    localparam int BAUD_CNT = CLK_FREQ / UART_BPS;
    localparam int HALF_CNT = BAUD_CNT / 2;
    localparam int CNT_W    = (BAUD_CNT > 2) ? $clog2(BAUD_CNT) : 1;
    localparam int TMO_CNT  = TIMEOUT_BITS * BAUD_CNT;
    localparam int TMO_W    = $clog2(TMO_CNT + 1);
    localparam int IDX_W    = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

    localparam logic [2:0] B_IDLE  = 3'd0;
    localparam logic [2:0] B_START = 3'd1;
    localparam logic [2:0] B_DATA  = 3'd2;
    localparam logic [2:0] B_STOP  = 3'd3;
    localparam logic [2:0] B_WAIT  = 3'd4;

    localparam logic [1:0] F_HUNT    = 2'd0;
    localparam logic [1:0] F_PAYLOAD = 2'd1;
`ifdef UART_FRAME_CHECKSUM_EN
    localparam logic [1:0] F_CHECK   = 2'd2;
`endif

    logic rx_meta, rx_sync, rx_prev;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= uart_rxd;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // ---------------- bit receiver ----------------
    logic [2:0]       bit_state, bit_next;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             half_hit, full_hit;
    logic             sample_data, byte_done, ferr_hit, cnt_clr;
    logic             ferr_pulse;

    assign half_hit = (baud_cnt == CNT_W'(HALF_CNT));
    assign full_hit = (baud_cnt == CNT_W'(BAUD_CNT - 1));

    always_ff @(posedge sys_clk) begin
        if (sys_rst) bit_state <= B_IDLE;
        else         bit_state <= bit_next;
    end

    always_comb begin
        bit_next = bit_state;
        case (bit_state)
            B_IDLE:  if (rx_prev && !rx_sync) bit_next = B_START;
            B_START: if (half_hit) bit_next = rx_sync ? B_IDLE : B_DATA;
            B_DATA:  if (full_hit && bit_idx == 3'd7) bit_next = B_STOP;
            B_STOP:  if (full_hit) bit_next = rx_sync ? B_IDLE : B_WAIT;
            B_WAIT:  if (rx_sync) bit_next = B_IDLE;
            default: bit_next = B_IDLE;
        endcase
    end

    always_comb begin
        sample_data = (bit_state == B_DATA) && full_hit;
        byte_done   = (bit_state == B_STOP) && full_hit && rx_sync;
        ferr_hit    = (bit_state == B_STOP) && full_hit && !rx_sync;
        cnt_clr     = (bit_state == B_IDLE) || (bit_state != bit_next) || full_hit;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            baud_cnt   <= '0;
            bit_idx    <= 3'd0;
            shift      <= 8'd0;
            byte_data  <= 8'd0;
            byte_valid <= 1'b0;
            ferr_pulse <= 1'b0;
        end else begin
            baud_cnt <= cnt_clr ? '0 : baud_cnt + 1'b1;
            if (bit_state == B_START) bit_idx <= 3'd0;
            if (sample_data) begin
                shift   <= {rx_sync, shift[7:1]};
                bit_idx <= bit_idx + 3'd1;
            end
            byte_valid <= byte_done;
            if (byte_done) byte_data <= shift;
            ferr_pulse <= ferr_hit;
        end
    end

    // ---------------- frame assembler ----------------
    logic [1:0]             frm_state, frm_next;
    logic [IDX_W-1:0]       idx;
    logic [8*NUM_BYTES-1:0] staging, merged;
    logic [TMO_W-1:0]       tmo_cnt;
    logic                   in_frame, last_byte, tmo_hit;
    logic                   start_frame, store_byte, frame_done, abort;
    logic [1:0]             abort_code;
`ifdef UART_FRAME_CHECKSUM_EN
    logic [7:0]             sum;
`endif

    always_ff @(posedge sys_clk) begin
        if (sys_rst) frm_state <= F_HUNT;
        else         frm_state <= frm_next;
    end

    always_comb begin
        frm_next = frm_state;
        case (frm_state)
            F_HUNT:    if (start_frame) frm_next = F_PAYLOAD;
`ifdef UART_FRAME_CHECKSUM_EN
            F_PAYLOAD: if (last_byte) frm_next = F_CHECK;
            F_CHECK:   if (byte_valid) frm_next = F_HUNT;
`else
            F_PAYLOAD: if (last_byte) frm_next = F_HUNT;
`endif
            default:   frm_next = F_HUNT;
        endcase
        if (abort) frm_next = F_HUNT;
    end

    always_comb begin
        in_frame    = (frm_state != F_HUNT);
        last_byte   = (frm_state == F_PAYLOAD) && byte_valid && (idx == IDX_W'(NUM_BYTES - 1));
        tmo_hit     = in_frame && (tmo_cnt == TMO_W'(TMO_CNT));
        start_frame = 1'b0;
        store_byte  = 1'b0;
        frame_done  = 1'b0;
        abort       = 1'b0;
        abort_code  = 2'b00;
        case (frm_state)
            F_HUNT:    start_frame = byte_valid && (byte_data == HEADER);
            F_PAYLOAD: begin
                store_byte = byte_valid;
`ifndef UART_FRAME_CHECKSUM_EN
                frame_done = last_byte;
`endif
            end
`ifdef UART_FRAME_CHECKSUM_EN
            F_CHECK: if (byte_valid) begin
                if (byte_data == sum) frame_done = 1'b1;
                else begin
                    abort      = 1'b1;
                    abort_code = 2'b01;
                end
            end
`endif
            default: ;
        endcase
        // A received byte restarts the timeout, so errors only act between bytes.
        if (in_frame && !byte_valid) begin
            if (ferr_pulse) begin
                abort      = 1'b1;
                abort_code = 2'b11;
            end else if (tmo_hit) begin
                abort      = 1'b1;
                abort_code = 2'b10;
            end
        end
        merged = staging;
        merged[{idx, 3'b000} +: 8] = byte_data;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            idx         <= '0;
            staging     <= '0;
            tmo_cnt     <= '0;
            frame_data  <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            err_code    <= 2'b00;
`ifdef UART_FRAME_CHECKSUM_EN
            sum         <= 8'd0;
`endif
        end else begin
            frame_valid <= frame_done;
            frame_err   <= abort;
            if (abort) err_code <= abort_code;
            tmo_cnt <= (!in_frame || byte_valid) ? '0 : tmo_cnt + 1'b1;
            if (start_frame) idx <= '0;
            if (store_byte) begin
                staging <= merged;
                idx     <= idx + 1'b1;
            end
`ifdef UART_FRAME_CHECKSUM_EN
            if (start_frame) sum <= 8'd0;
            if (store_byte)  sum <= sum + byte_data;
            if (frame_done)  frame_data <= staging;
`else
            if (frame_done)  frame_data <= merged;
`endif
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_frame_rx.sv
//------------------------------------------------------------------------------
// Module  : tb_uart_frame_rx
// Brief   : Directed bench for uart_frame_rx at 16 clocks per bit.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_uart_frame_rx;

    localparam int BAUD = 16;
`ifdef UART_FRAME_CHECKSUM_EN
    localparam int FRAME_LEN = 7;
`else
    localparam int FRAME_LEN = 6;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rxd = 1'b1;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic [39:0] frame_data;
    logic        frame_valid;
    logic        frame_err;
    logic [1:0]  err_code;

    int n_tests = 0;
    int n_fail  = 0;
    int fv_cnt = 0, fe_cnt = 0, bv_cnt = 0, both_cnt = 0;
    int fv0, fe0, bv0;

    uart_frame_rx #(
        .CLK_FREQ(1_000_000), .UART_BPS(62_500), .NUM_BYTES(5),
        .HEADER(8'hA5), .TIMEOUT_BITS(20)
    ) dut (
        .sys_clk(clk), .sys_rst(rst), .uart_rxd(rxd),
        .byte_data(byte_data), .byte_valid(byte_valid),
        .frame_data(frame_data), .frame_valid(frame_valid),
        .frame_err(frame_err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_valid) fv_cnt <= fv_cnt + 1;
        if (frame_err)   fe_cnt <= fe_cnt + 1;
        if (byte_valid)  bv_cnt <= bv_cnt + 1;
        if (frame_valid && frame_err) both_cnt <= both_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle_bits(input int n);
        rxd = 1'b1;
        repeat (n * BAUD) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit good_stop);
        rxd = 1'b0;
        repeat (BAUD) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (BAUD) @(negedge clk);
        end
        rxd = good_stop;
        repeat (BAUD) @(negedge clk);
        idle_bits(2);
    endtask

    task automatic send_frame(input logic [39:0] pl, input logic [7:0] cks, input int bad_idx);
        send_byte(8'hA5, 1'b1);
        for (int i = 0; i < 5; i++) send_byte(pl[8*i +: 8], i != bad_idx);
`ifdef UART_FRAME_CHECKSUM_EN
        send_byte(cks, 1'b1);
`endif
        idle_bits(2);
    endtask

    task automatic snap();
        @(negedge clk);
        fv0 = fv_cnt; fe0 = fe_cnt; bv0 = bv_cnt;
    endtask

    initial begin
        repeat (4) @(negedge clk);
        rst = 1'b0;
        check("rst_frame_data",  64'(frame_data),  64'h0);
        check("rst_frame_valid", 64'(frame_valid), 64'h0);
        check("rst_frame_err",   64'(frame_err),   64'h0);
        check("rst_err_code",    64'(err_code),    64'h0);
        check("rst_byte_data",   64'(byte_data),   64'h0);
        check("rst_byte_valid",  64'(byte_valid),  64'h0);
        idle_bits(2);

        // clean frame
        snap();
        send_frame(40'h5544332211, 8'hFF, -1);
        check("t1_fv_count",   64'(fv_cnt - fv0), 64'd1);
        check("t1_fe_count",   64'(fe_cnt - fe0), 64'd0);
        check("t1_frame_data", 64'(frame_data),   64'h5544332211);
`ifdef UART_FRAME_CHECKSUM_EN
        check("t1_byte_data",  64'(byte_data),    64'hFF);
`else
        check("t1_byte_data",  64'(byte_data),    64'h55);
`endif

        // checksum mismatch (or, without checksum, a second payload)
        snap();
`ifdef UART_FRAME_CHECKSUM_EN
        send_frame(40'h5544332211, 8'h00, -1);
        check("t2_fe_count",   64'(fe_cnt - fe0), 64'd1);
        check("t2_err_code",   64'(err_code),     64'd1);
        check("t2_fv_count",   64'(fv_cnt - fv0), 64'd0);
        check("t2_frame_data", 64'(frame_data),   64'h5544332211);
`else
        send_frame(40'hAA99887766, 8'h00, -1);
        check("t2_fv_count",   64'(fv_cnt - fv0), 64'd1);
        check("t2_fe_count",   64'(fe_cnt - fe0), 64'd0);
        check("t2_frame_data", 64'(frame_data),   64'hAA99887766);
`endif

        // resync and glitch
        snap();
        send_byte(8'h00, 1'b1);
        send_byte(8'h12, 1'b1);
        rxd = 1'b0;
        repeat (5) @(negedge clk);
        idle_bits(3);
        send_frame(40'h5544332211, 8'hFF, -1);
        check("t3_bv_count",   64'(bv_cnt - bv0), 64'(2 + FRAME_LEN));
        check("t3_fv_count",   64'(fv_cnt - fv0), 64'd1);
        check("t3_frame_data", 64'(frame_data),   64'h5544332211);

        // inter-byte timeout
        snap();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        idle_bits(25);
        check("t4_fe_count", 64'(fe_cnt - fe0), 64'd1);
        check("t4_err_code", 64'(err_code),     64'd2);
        check("t4_fv_count", 64'(fv_cnt - fv0), 64'd0);
        snap();
        send_frame(40'h0102030405, 8'h0F, -1);
        check("t4_recover_fv",   64'(fv_cnt - fv0), 64'd1);
        check("t4_recover_data", 64'(frame_data),   64'h0102030405);

        // framing error on the third frame byte
        snap();
        send_frame(40'h5544332211, 8'hFF, 1);
        check("t5_fe_count",   64'(fe_cnt - fe0), 64'd1);
        check("t5_err_code",   64'(err_code),     64'd3);
        check("t5_fv_count",   64'(fv_cnt - fv0), 64'd0);
        check("t5_frame_data", 64'(frame_data),   64'h0102030405);
        snap();
        send_frame(40'h5544332211, 8'hFF, -1);
        check("t5_recover_fv", 64'(fv_cnt - fv0), 64'd1);

        // reset mid-frame
        send_byte(8'hA5, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_frame_data", 64'(frame_data), 64'h0);
        check("t6_err_code",   64'(err_code),   64'h0);
        check("t6_byte_data",  64'(byte_data),  64'h0);
        check("t6_frame_err",  64'(frame_err),  64'h0);
        snap();
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b1);
        send_byte(8'h55, 1'b1);
        send_byte(8'hFF, 1'b1);
        idle_bits(2);
        check("t6_no_fv", 64'(fv_cnt - fv0), 64'd0);
        snap();
        send_frame(40'h5544332211, 8'hFF, -1);
        check("t6_recover_fv",   64'(fv_cnt - fv0), 64'd1);
        check("t6_recover_data", 64'(frame_data),   64'h5544332211);

        check("never_fv_and_fe", 64'(both_cnt), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
